result_packer: RTL and testbench

RESULT_PACKER -- requirements
Module: result_packer

---
 rtl/result_packer_pkg.sv | 13 +
 rtl/result_packer_fifo.sv | 69 ++++++
 rtl/result_packer.sv | 91 +++++++++
 tb/tb_result_packer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/result_packer_pkg.sv
// Shared types for the result packer: the packed output word and the FIFO entry.
package result_packer_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t      data;
        logic [2:0] bytes;
    } entry_t;

endpackage

// File: rtl/result_packer_fifo.sv
// Synchronous circular FIFO of packed entries; head is presented combinationally.
module result_packer_fifo
    import result_packer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              push_i,
    input  entry_t                            entry_i,
    input  logic                              pop_i,
    output entry_t                            entry_o,
    output logic                              full_o,
    output logic                              empty_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    entry_t        mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign entry_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is only observed while count is non-zero.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

endmodule

// File: rtl/result_packer.sv
// Packs mux-stage bytes into 32-bit words (first byte in [7:0]) and queues them downstream.
module result_packer
    import result_packer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [7:0]  data_i,
    input  logic        flush_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [31:0] word_o,
    output logic [2:0]  bytes_o,
    input  logic        ready_i,
    output logic [15:0] word_cnt_o
);

    word_t       pack_q, pack_d;
    logic [1:0]  pack_cnt_q, pack_cnt_d;
    logic [15:0] word_cnt_q, word_cnt_d;

    word_t       pack_next;
    logic [2:0]  cnt_next;
    logic        accept_byte, accept_flush;
    logic        push, pop;
    entry_t      push_entry, head_entry;
    logic        fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;
    logic        fifo_count_unused;

    assign ready_o      = !fifo_full;
    assign valid_o      = !fifo_empty;
    assign accept_byte  = valid_i && ready_o;
    assign accept_flush = flush_i && ready_o;
    assign pop          = valid_o && ready_i;
    assign fifo_count_unused = ^fifo_count;

    assign word_o     = valid_o ? head_entry.data  : '0;
    assign bytes_o    = valid_o ? head_entry.bytes : '0;
    assign word_cnt_o = word_cnt_q;

    // The byte accepted this cycle is merged first, so a same-cycle flush sees it.
    always_comb begin
        pack_next = pack_q;
        cnt_next  = {1'b0, pack_cnt_q};
        if (accept_byte) begin
            pack_next[{pack_cnt_q, 3'b000} +: 8] = data_i;
            cnt_next = {1'b0, pack_cnt_q} + 3'd1;
        end
        push = (cnt_next == 3'(BYTES_PER_WORD)) || (accept_flush && (cnt_next != 3'd0));
        push_entry.data  = pack_next;
        push_entry.bytes = cnt_next;
        if (push) begin
            pack_d     = '0;
            pack_cnt_d = '0;
        end else begin
            pack_d     = pack_next;
            pack_cnt_d = cnt_next[1:0];
        end
        word_cnt_d = pop ? word_cnt_q + 16'd1 : word_cnt_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pack_q     <= '0;
            pack_cnt_q <= '0;
            word_cnt_q <= '0;
        end else begin
            pack_q     <= pack_d;
            pack_cnt_q <= pack_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    result_packer_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .entry_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_result_packer.sv
// Directed and random checks of result_packer against a byte-list/word-queue reference model.
module tb_result_packer;

    localparam int unsigned DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [7:0]  data_i;
    logic        flush_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] word_o;
    logic [2:0]  bytes_o;
    logic        ready_i;
    logic [15:0] word_cnt_o;

    result_packer #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .flush_i    (flush_i),
        .ready_o    (ready_o),
        .valid_o    (valid_o),
        .word_o     (word_o),
        .bytes_o    (bytes_o),
        .ready_i    (ready_i),
        .word_cnt_o (word_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] data;
        int          n;
    } exp_t;

    exp_t       fq[$];
    logic [7:0] pend[$];
    int         wcnt;
    int         checks;
    int         errors;
    bit         check_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: compare outputs with the model, advance the model, then cross the edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic f, input logic r,
                         output bit acc);
        exp_t        e;
        logic [31:0] w;
        bit          rdy;
        valid_i = v;
        data_i  = d;
        flush_i = f;
        ready_i = r;
        if (check_en) begin
            chk("ready_o", 32'(ready_o), 32'(fq.size() < DEPTH));
            chk("valid_o", 32'(valid_o), 32'(fq.size() != 0));
            chk("word_o", word_o, (fq.size() != 0) ? fq[0].data : 32'h0);
            chk("bytes_o", 32'(bytes_o), (fq.size() != 0) ? 32'(fq[0].n) : 32'h0);
            chk("word_cnt_o", 32'(word_cnt_o), 32'(wcnt));
        end
        rdy = (fq.size() < DEPTH);
        if (fq.size() != 0 && r) begin
            void'(fq.pop_front());
            wcnt = (wcnt + 1) % 65536;
        end
        acc = v && rdy;
        if (acc) pend.push_back(d);
        if (pend.size() == 4 || (f && rdy && pend.size() != 0)) begin
            w = '0;
            foreach (pend[i]) w |= 32'(pend[i]) << (8 * i);
            e.data = w;
            e.n    = pend.size();
            fq.push_back(e);
            pend.delete();
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        bit         acc;
        logic [7:0] bp_bytes[12];
        int         idx;
        int         guard;
        logic [31:0] held;

        checks   = 0;
        errors   = 0;
        wcnt     = 0;
        check_en = 1'b1;
        rst_i    = 1'b1;
        valid_i  = 1'b0;
        data_i   = '0;
        flush_i  = 1'b0;
        ready_i  = 1'b0;

        #1;
        chk("rst_valid_o", 32'(valid_o), 32'h0);
        chk("rst_word_o", word_o, 32'h0);
        chk("rst_bytes_o", 32'(bytes_o), 32'h0);
        chk("rst_word_cnt_o", 32'(word_cnt_o), 32'h0);
        chk("rst_ready_o", 32'(ready_o), 32'h1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Packing of four bytes.
        cycle(1, 8'h11, 0, 1, acc);
        chk("first_byte_accepted", 32'(acc), 32'h1);
        cycle(1, 8'h22, 0, 1, acc);
        cycle(1, 8'h33, 0, 1, acc);
        cycle(1, 8'h44, 0, 1, acc);
        chk("pack_valid", 32'(valid_o), 32'h1);
        chk("pack_word", word_o, 32'h44332211);
        chk("pack_bytes", 32'(bytes_o), 32'h4);
        chk("pack_cnt_before", 32'(word_cnt_o), 32'h0);
        cycle(0, 8'h00, 0, 1, acc);
        chk("pack_cnt_after", 32'(word_cnt_o), 32'h1);

        // Partial flush, then a lone flush that must not emit anything.
        cycle(1, 8'hAA, 0, 1, acc);
        cycle(1, 8'hBB, 0, 1, acc);
        cycle(0, 8'h00, 1, 1, acc);
        chk("flush_word", word_o, 32'h0000BBAA);
        chk("flush_bytes", 32'(bytes_o), 32'h2);
        cycle(0, 8'h00, 1, 1, acc);
        chk("lone_flush_none", 32'(valid_o), 32'h0);
        cycle(0, 8'h00, 0, 1, acc);
        chk("lone_flush_none2", 32'(valid_o), 32'h0);

        // Flush coinciding with the fourth byte.
        cycle(1, 8'h01, 0, 1, acc);
        cycle(1, 8'h02, 0, 1, acc);
        cycle(1, 8'h03, 0, 1, acc);
        cycle(1, 8'h04, 1, 1, acc);
        chk("f4_word", word_o, 32'h04030201);
        chk("f4_bytes", 32'(bytes_o), 32'h4);
        cycle(0, 8'h00, 0, 1, acc);
        chk("f4_single", 32'(valid_o), 32'h0);

        // Backpressure: 12 bytes offered with ready_i low.
        foreach (bp_bytes[i]) bp_bytes[i] = 8'(8'h50 + i);
        idx = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1, bp_bytes[idx], 0, 0, acc);
            if (acc) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'd8);
        chk("bp_ready_low", 32'(ready_o), 32'h0);
        held = word_o;
        cycle(1, bp_bytes[idx], 0, 0, acc);
        chk("bp_word_held", word_o, held);
        chk("bp_word_val", word_o, 32'h53525150);
        guard = 0;
        while ((idx < 12 || fq.size() != 0 || pend.size() != 0) && guard < 100) begin
            cycle(idx < 12, (idx < 12) ? bp_bytes[idx] : 8'h00, 0, 1, acc);
            if (acc) idx++;
            guard++;
        end
        chk("bp_drain_timeout", 32'(guard < 100), 32'h1);
        chk("bp_all_accepted", 32'(idx), 32'd12);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 2) != 0), acc);
        end

        // Reset mid-operation: one word queued plus three bytes packed.
        for (int i = 0; i < 7; i++) cycle(1, 8'(8'hC0 + i), 0, 0, acc);
        rst_i = 1'b1;
        #1;
        chk("mrst_valid_o", 32'(valid_o), 32'h0);
        chk("mrst_word_o", word_o, 32'h0);
        chk("mrst_bytes_o", 32'(bytes_o), 32'h0);
        chk("mrst_word_cnt_o", 32'(word_cnt_o), 32'h0);
        chk("mrst_ready_o", 32'(ready_o), 32'h1);
        #1;
        rst_i = 1'b0;
        fq.delete();
        pend.delete();
        wcnt = 0;
        cycle(1, 8'hD1, 0, 1, acc);
        chk("post_rst_accept", 32'(acc), 32'h1);
        cycle(1, 8'hD2, 0, 1, acc);
        cycle(1, 8'hD3, 0, 1, acc);
        cycle(1, 8'hD4, 0, 1, acc);
        chk("post_rst_word", word_o, 32'hD4D3D2D1);
        chk("post_rst_bytes", 32'(bytes_o), 32'h4);
        cycle(0, 8'h00, 0, 1, acc);
        chk("post_rst_cnt", 32'(word_cnt_o), 32'h1);
        chk("post_rst_empty", 32'(valid_o), 32'h0);

        // Counter wrap: one word per cycle via byte+flush until the count hits FFFF.
        check_en = 1'b0;
        guard = 0;
        while (wcnt != 65535 && guard < 70000) begin
            cycle(1, 8'($urandom), 1, 1, acc);
            guard++;
        end
        check_en = 1'b1;
        chk("wrap_timeout", 32'(guard < 70000), 32'h1);
        cycle(0, 8'h00, 0, 0, acc);
        chk("wrap_ffff", 32'(word_cnt_o), 32'h0000FFFF);
        chk("wrap_have_word", 32'(valid_o), 32'h1);
        cycle(0, 8'h00, 0, 1, acc);
        chk("wrap_zero", 32'(word_cnt_o), 32'h0);
        cycle(0, 8'h00, 0, 1, acc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
